bram_stream_reader: RTL and testbench

- Read-side initiator for the synchronous dual-port block RAM.
- Accepts a burst command (base address, length) and drives one RAM read port (address; write-enable tied low).
- Absorbs the RAM's fixed 1-cycle read latency and emits the words on a valid/ready stream with last-beat marking.
- Sits between the RAM's port B and downstream consumers (e.g. UART/DMA transmit path) while port A is written by the producer.

---
 rtl/bram_rd_pkg.sv | 22 ++
 rtl/bram_rd_skid_fifo.sv | 59 +++++
 rtl/bram_stream_reader.sv | 148 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the block-RAM stream reader.
// Define BRAM_READER_LAT2_EN for a RAM with an output register (2-cycle read latency).
package bram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

`ifdef BRAM_READER_LAT2_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam int FIFO_DEPTH = RD_LAT + 1;
  // Wide enough for FIFO occupancy plus reads in flight plus one.
  localparam int CNT_W = 3;

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// Small synchronous FIFO holding captured RAM words (plus last flag) ahead of the stream port.
// Push and pop in the same cycle leave the occupancy unchanged.
module bram_rd_skid_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader for one block-RAM read port, presenting the words on a valid/ready stream.
// BRAM_READER_LAT2_EN selects 2-cycle RAM read latency (deeper in-flight pipe and FIFO).
//
// state    | meaning
// ST_IDLE  | waiting for start; first read is issued in the start cycle
// ST_RUN   | issuing reads while credit allows
// ST_DRAIN | all reads issued; waiting for the last beat to be accepted
// ST_FIN   | one-cycle done pulse
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [RD_LAT-1:0]     infl_vld_q, infl_vld_d;
  logic [RD_LAT-1:0]     infl_last_q, infl_last_d;

  logic                  issue, issue_last, pop, fifo_empty;
  logic [CNT_W-1:0]      fifo_count, infl_count;
  logic [DATA_WIDTH:0]   fifo_head;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    mem_addr_d = mem_addr_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    pop        = !fifo_empty && m_ready;

    infl_count = '0;
    for (int i = 0; i < RD_LAT; i++) infl_count = infl_count + CNT_W'(infl_vld_q[i]);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          if (len == '0) begin
            state_d = ST_FIN;
          end else begin
            issue      = 1'b1;
            issue_last = (len == LEN_ONE);
            mem_addr_d = base_addr;
            issued_d   = LEN_ONE;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A word popped this cycle frees its slot in time for the read issued now.
        if (issued_q < len_q &&
            (fifo_count + infl_count < CNT_W'(FIFO_DEPTH) + CNT_W'(pop))) begin
          issue      = 1'b1;
          issue_last = (issued_q == len_q - 1'b1);
          mem_addr_d = base_q + issued_q[ADDR_WIDTH-1:0];
          issued_d   = issued_q + 1'b1;
        end
        if (issued_d == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && fifo_head[DATA_WIDTH]) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    infl_vld_d     = infl_vld_q;
    infl_last_d    = infl_last_q;
    infl_vld_d[0]  = issue;
    infl_last_d[0] = issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      infl_vld_d[i]  = infl_vld_q[i-1];
      infl_last_d[i] = infl_last_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      mem_addr_q  <= '0;
      infl_vld_q  <= '0;
      infl_last_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      mem_addr_q  <= mem_addr_d;
      infl_vld_q  <= infl_vld_d;
      infl_last_q <= infl_last_d;
    end
  end

  bram_rd_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (infl_vld_q[RD_LAT-1]),
    .wdata ({infl_last_q[RD_LAT-1], mem_rdata}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign mem_addr = mem_addr_d;
  assign mem_we   = 1'b0;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_FIN);
  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_head[DATA_WIDTH-1:0];
  assign m_last   = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: RAM model on the read port, expected-beat queue
// built from base/len arithmetic, and cycle-timing checks when the consumer never stalls.
module tb_bram_stream_reader;
  import bram_rd_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, mem_we, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, m_data;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd1, rd2;
  logic [DW:0]   exp_q [$];

  int n_checks = 0;
  int n_fail = 0;

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Read port of the RAM: one register stage, plus the optional output register.
  always @(posedge clk) begin
    rd1 <= ram[mem_addr];
    rd2 <= rd1;
  end
  assign mem_rdata = (RD_LAT == 2) ? rd2 : rd1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[c % 6];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode, input bit poke);
    int c, nbeat;
    bit got_done, stall_prev, last_prev, seen_valid;
    logic [DW:0] prev_beat, e;
    exp_q.delete();
    for (int i = 0; i < int'(l); i++)
      exp_q.push_back({(i == int'(l) - 1), ram[(int'(b) + i) % DEPTH]});
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l; m_ready = rdy(mode, 0);
    c = 0; nbeat = 0; got_done = 0; stall_prev = 0; last_prev = 0; seen_valid = 0;
    prev_beat = '0;
    while (!got_done && c < 5000) begin
      @(negedge clk);
      if (mode == 0 && c < int'(l)) check_eq("mem_addr", 32'(mem_addr), 32'((int'(b) + c) % DEPTH));
      if (c > 0 && !done && l != '0) check_eq("busy", 32'(busy), 32'd1);
      if (stall_prev) check_eq("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_beat}));
      if (m_valid) seen_valid = 1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", 32'({m_last, m_data}), 32'(e));
          if (mode == 0) check_eq("beat_cyc", 32'(c), 32'(RD_LAT + 1 + nbeat));
        end
        nbeat++;
      end
      if (done) begin
        got_done = 1;
        check_eq("done_busy", 32'(busy), 32'd0);
        if (l == '0) begin
          check_eq("len0_done_cyc", 32'(c), 32'd1);
          check_eq("len0_no_valid", 32'(seen_valid), 32'd0);
        end else begin
          check_eq("done_after_last", 32'(last_prev), 32'd1);
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
      last_prev  = m_valid && m_ready && m_last;
      c++;
      if (!got_done) begin
        @(posedge clk); #1;
        start = poke && (c == 3);
        if (poke && c == 3) begin
          base_addr = AW'($urandom);
          len = (AW+1)'($urandom_range(1, 50));
        end
        m_ready = rdy(mode, c);
      end
    end
    check_eq("done_seen", 32'(got_done), 32'd1);
    check_eq("all_beats", 32'(nbeat), 32'(l));
    @(posedge clk); #1;
    start = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("mem_we", 32'(mem_we), 32'd0);
  endtask

  task automatic reset_mid_burst(input logic [AW-1:0] b);
    int beats;
    bit hit;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = (AW+1)'(16); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0; hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (m_valid) begin
        if (beats == 2) begin
          rst_n = 1'b0;
          #1;
          check_eq("rst_valid", 32'(m_valid), 32'd0);
          check_eq("rst_busy", 32'(busy), 32'd0);
          check_eq("rst_done", 32'(done), 32'd0);
          check_eq("rst_last", 32'(m_last), 32'd0);
          hit = 1;
        end else begin
          beats++;
        end
      end
    end
    check_eq("rst_reached", 32'(hit), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rst_hold", 32'({done, m_valid, busy}), 32'd0);
    end
    m_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", 32'({m_valid, busy, done, m_last, mem_we}), 32'd0);
    check_eq("reset_addr", 32'(mem_addr), 32'd0);
    check_eq("reset_data", 32'(m_data), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) ram[16 + i] = DW'(8'hA0 + i);
    run_burst(AW'(10'h010), (AW+1)'(4), 0, 0);

    run_burst(AW'(10'h3FE), (AW+1)'(4), 0, 0);
    run_burst(AW'($urandom), (AW+1)'(8), 1, 0);
    run_burst(AW'($urandom), (AW+1)'(0), 0, 0);
    run_burst(AW'(10'h3FF), (AW+1)'(1), 0, 0);

    reset_mid_burst(AW'(10'h100));
    run_burst(AW'(10'h123), (AW+1)'(6), 0, 0);

    run_burst(AW'(10'h200), (AW+1)'(12), 1, 1);

    for (int t = 0; t < 12; t++)
      run_burst(AW'($urandom), (AW+1)'($urandom_range(1, 40)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    run_burst(AW'($urandom), (AW+1)'(DEPTH), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
